// File: rtl/gray_sync_decoder.sv
// Synchronizes a foreign-domain gray count, decodes it to binary and accumulates
// the per-cycle increments into a saturating delta drained by a valid/ready handshake.
module gray_sync_decoder #(
  parameter int N           = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] gray_in,
  input  logic         clr,
  output logic [N-1:0] bin_out,
  output logic [N-1:0] delta,
  output logic         delta_valid,
  input  logic         delta_ready,
  output logic         err,
  output logic         ovf
);

  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] g_sync;
  logic [N-1:0] g_prev_q;
  logic [N-1:0] bin_out_q;
  logic [N-1:0] bin_new;
  logic [N-1:0] diff;
  logic         step_illegal;
  logic [N-1:0] inc;
  logic         handshake;
  logic [N-1:0] acc_base;
  logic [N-1:0] acc_add;
  logic [N:0]   acc_sum;
  logic [N-1:0] acc_q, acc_d;
  logic         delta_valid_q, delta_valid_d;
  logic         err_q, err_d;
  logic         ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign g_sync = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all gray bits at or above it.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dec
      assign bin_new[gi] = ^g_sync[N-1:gi];
    end
  endgenerate

  // More than one bit set in the difference means a multi-bit (illegal) step.
  assign diff         = g_sync ^ g_prev_q;
  assign step_illegal = |(diff & (diff - N'(1)));
  assign inc          = bin_new - bin_out_q;

  assign handshake = delta_valid_q & delta_ready;
  assign acc_base  = handshake ? '0 : acc_q;
  assign acc_add   = step_illegal ? '0 : inc;
  assign acc_sum   = {1'b0, acc_base} + {1'b0, acc_add};

  always_comb begin
    acc_d = acc_q;
    err_d = err_q;
    ovf_d = ovf_q;
    if (clr) begin
      acc_d = '0;
      err_d = 1'b0;
      ovf_d = 1'b0;
    end else begin
      err_d = err_q | step_illegal;
      if (acc_sum[N]) begin
        acc_d = '1;
        ovf_d = 1'b1;
      end else begin
        acc_d = acc_sum[N-1:0];
      end
    end
    delta_valid_d = (acc_d != '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      g_prev_q      <= '0;
      bin_out_q     <= '0;
      acc_q         <= '0;
      delta_valid_q <= 1'b0;
      err_q         <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      g_prev_q      <= g_sync;
      bin_out_q     <= bin_new;
      acc_q         <= acc_d;
      delta_valid_q <= delta_valid_d;
      err_q         <= err_d;
      ovf_q         <= ovf_d;
    end
  end

  assign bin_out     = bin_out_q;
  assign delta       = acc_q;
  assign delta_valid = delta_valid_q;
  assign err         = err_q;
  assign ovf         = ovf_q;

endmodule
